router_pkt_framer: RTL

//  Upstream packet source for the 1x3 router. Accepts a command (dest addr, length) plus payload bytes.

---
 rtl/router_pkt_framer_if.sv | 29 ++
 rtl/router_pkt_framer.sv | 98 +++++++++
 2 files changed

// File: rtl/router_pkt_framer_if.sv
// router_pkt_framer_if: command, payload and router-side signals of the packet framer
interface router_pkt_framer_if #(
    parameter int LEN_W = 6
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_addr;
    logic [LEN_W-1:0] cmd_len;
    logic             cmd_bad_par;
    logic             pl_valid;
    logic             pl_ready;
    logic [7:0]       pl_data;
    logic             busy;
    logic             pkt_valid;
    logic [7:0]       data_out;
    logic             cmd_err;
    logic             pkt_done;
    logic [7:0]       pkt_cnt;

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, cmd_bad_par, pl_valid, pl_data, busy,
        output cmd_ready, pl_ready, pkt_valid, data_out, cmd_err, pkt_done, pkt_cnt
    );

    modport master (
        output cmd_valid, cmd_addr, cmd_len, cmd_bad_par, pl_valid, pl_data, busy,
        input  cmd_ready, pl_ready, pkt_valid, data_out, cmd_err, pkt_done, pkt_cnt
    );
endinterface

// File: rtl/router_pkt_framer.sv
// router_pkt_framer: buffers a command's payload, then emits header, payload and parity to the router
module router_pkt_framer #(
    parameter int LEN_W   = 6,
    parameter int GAP_CYC = 1
) (
    input logic                clk,
    input logic                rst,
    router_pkt_framer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, HDR, DATA, PAR, GAP} state_t;

    state_t           state;
    logic [7:0]       mem [0:(2**LEN_W)-2];
    logic [LEN_W-1:0] idx, len, last, rd_idx;
    logic [1:0]       addr;
    logic             bad;
    logic [7:0]       par, rd_data;
    logic [3:0]       gcnt;

    assign bus.cmd_ready = !rst && state == IDLE;
    assign bus.pl_ready  = !rst && state == LOAD;

    // single read port: HDR prefetches entry 0, DATA prefetches the next entry
    always_comb begin
        last    = len - 1'b1;
        rd_idx  = state == HDR ? '0 : idx + 1'b1;
        rd_data = mem[rd_idx];
    end

    always_ff @(posedge clk)
        if (state == LOAD && bus.pl_valid) mem[idx] <= bus.pl_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bus.pkt_valid <= 1'b0;
            bus.data_out <= '0;
            bus.cmd_err  <= 1'b0;
            bus.pkt_done <= 1'b0;
            bus.pkt_cnt  <= '0;
            idx          <= '0;
            len          <= '0;
            addr         <= '0;
            bad          <= 1'b0;
            par          <= '0;
            gcnt         <= '0;
        end else begin
            bus.cmd_err  <= 1'b0;
            bus.pkt_done <= 1'b0;
            case (state)
                IDLE: if (bus.cmd_valid) begin
                    addr <= bus.cmd_addr;
                    len  <= bus.cmd_len;
                    bad  <= bus.cmd_bad_par;
                    if (bus.cmd_addr == 2'd3 || bus.cmd_len == '0) bus.cmd_err <= 1'b1;
                    else begin
                        state <= LOAD;
                        idx   <= '0;
                        par   <= 8'({bus.cmd_len, bus.cmd_addr});
                    end
                end
                LOAD: if (bus.pl_valid) begin
                    par <= par ^ bus.pl_data;
                    if (idx == last) begin
                        state         <= HDR;
                        bus.pkt_valid <= 1'b1;
                        bus.data_out  <= 8'({len, addr});
                    end else idx <= idx + 1'b1;
                end
                HDR: if (!bus.busy) begin
                    state        <= DATA;
                    idx          <= '0;
                    bus.data_out <= rd_data;
                end
                DATA: if (!bus.busy) begin
                    if (idx == last) begin
                        state         <= PAR;
                        bus.pkt_valid <= 1'b0;
                        bus.data_out  <= par ^ {8{bad}};
                    end else begin
                        idx          <= idx + 1'b1;
                        bus.data_out <= rd_data;
                    end
                end
                PAR: if (!bus.busy) begin
                    state        <= GAP;
                    gcnt         <= '0;
                    bus.data_out <= '0;
                    bus.pkt_done <= 1'b1;
                    bus.pkt_cnt  <= bus.pkt_cnt + 8'd1;
                end
                GAP: if (gcnt == 4'(GAP_CYC - 1)) state <= IDLE;
                     else gcnt <= gcnt + 4'd1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
